// File: rtl/db_req_if.sv
// SRIO logical-layer request/response AXIS channels shared by the doorbell sequencer and its link peer.
interface db_req_if;
    logic        ireq_tvalid_o;
    logic        ireq_tready_in;
    logic        ireq_tlast_o;
    logic [63:0] ireq_tdata_o;
    logic [7:0]  ireq_tkeep_o;
    logic [31:0] ireq_tuser_o;

    logic        iresp_tvalid_in;
    logic        iresp_tready_o;
    logic        iresp_tlast_in;
    logic [63:0] iresp_tdata_in;
    logic [7:0]  iresp_tkeep_in;
    logic [31:0] iresp_tuser_in;

    modport master (
        output ireq_tvalid_o, ireq_tlast_o, ireq_tdata_o, ireq_tkeep_o, ireq_tuser_o, iresp_tready_o,
        input  ireq_tready_in, iresp_tvalid_in, iresp_tlast_in, iresp_tdata_in, iresp_tkeep_in, iresp_tuser_in
    );

    modport slave (
        input  ireq_tvalid_o, ireq_tlast_o, ireq_tdata_o, ireq_tkeep_o, ireq_tuser_o, iresp_tready_o,
        output ireq_tready_in, iresp_tvalid_in, iresp_tlast_in, iresp_tdata_in, iresp_tkeep_in, iresp_tuser_in
    );
endinterface

// File: rtl/db_req.sv
// Initiator-side SRIO doorbell/NWRITE sequencer: self-check doorbell handshake with retries,
// one counter-payload NWRITE, then a data doorbell whose echo completes the sequence.
module db_req #(
    parameter logic [33:0] NWR_ADDR    = 34'h0,
    parameter int          MAX_RETRY   = 4,
    parameter int          RETRY_GAP   = 16,
    parameter int          RSP_TIMEOUT = 4096
) (
    input  logic        log_clk,
    input  logic        log_rst_n,
    input  logic [15:0] src_id,
    input  logic [15:0] des_id,
    input  logic        start_in,
    input  logic [7:0]  nwr_size_in,
    db_req_if.master    srio,
    output logic        busy_o,
    output logic        done_o,
    output logic        error_o,
    output logic        ed_ready_o
);

    localparam logic [15:0] DB_SELF   = 16'h0101;
    localparam logic [15:0] DB_READY  = 16'h0100;
    localparam logic [15:0] DB_NREADY = 16'h01FF;
    localparam logic [15:0] DB_DATA   = 16'h0200;
    localparam logic [3:0]  FTYPE_DB  = 4'hA;
    localparam logic [3:0]  FTYPE_NWR = 4'h5;
    localparam logic [3:0]  TTYPE_NWR = 4'h4;

    typedef enum logic [3:0] {
        IDLE,
        SELF_DB,
        WAIT_RDY,
        RETRY,
        NWR_HDR,
        NWR_DATA,
        DATA_DB,
        WAIT_ACK,
        ERR
    } state_t;

    state_t      state;
    logic [7:0]  tid;
    logic [15:0] timer;
    logic [7:0]  gap_cnt;
    logic [3:0]  retry_cnt;
    logic [4:0]  beat;
    logic [7:0]  size_q;

    logic        req_valid;
    logic        req_last;
    logic [63:0] req_data;
    logic [7:0]  req_keep;
    logic [31:0] req_user;

    logic        tx_fire;
    logic        rsp_db;
    logic [15:0] rsp_info;
    logic [2:0]  last_rem;
    logic [7:0]  last_keep;
    logic [4:0]  last_idx;
    logic [4:0]  next_beat;
    logic        unused_rsp;

    function automatic logic [63:0] db_beat(input logic [7:0] t, input logic [15:0] info);
        return {t, FTYPE_DB, 4'h0, 1'b0, 2'h1, 1'b0, 12'h0, info, 16'h0};
    endfunction

    function automatic logic [63:0] nwr_hdr(input logic [7:0] t, input logic [7:0] sz);
        return {t, FTYPE_NWR, TTYPE_NWR, 1'b0, 2'h1, 1'b0, sz, 2'b00, NWR_ADDR};
    endfunction

    assign srio.ireq_tvalid_o  = req_valid;
    assign srio.ireq_tlast_o   = req_last;
    assign srio.ireq_tdata_o   = req_data;
    assign srio.ireq_tkeep_o   = req_keep;
    assign srio.ireq_tuser_o   = req_user;
    assign srio.iresp_tready_o = 1'b1;

    assign tx_fire   = req_valid && srio.ireq_tready_in;
    assign rsp_db    = srio.iresp_tvalid_in && (srio.iresp_tdata_in[55:52] == FTYPE_DB);
    assign rsp_info  = srio.iresp_tdata_in[31:16];

    // Partial final beat: valid bytes are packed from the MSB lane down.
    assign last_rem  = size_q[2:0] + 3'd1;
    assign last_keep = (last_rem == 3'd0) ? 8'hFF : 8'(8'hFF << (4'd8 - {1'b0, last_rem}));
    assign last_idx  = size_q[7:3];
    assign next_beat = beat + 5'd1;

    assign unused_rsp = ^{srio.iresp_tlast_in, srio.iresp_tkeep_in, srio.iresp_tuser_in,
                          srio.iresp_tdata_in[63:56], srio.iresp_tdata_in[51:32], srio.iresp_tdata_in[15:0]};

    // Sequencer FSM; every packet beat is loaded on the edge that enters its send state so the
    // AXIS outputs come straight from registers and stay frozen under back-pressure.
    always_ff @(posedge log_clk or negedge log_rst_n) begin
        if (!log_rst_n) begin
            state      <= IDLE;
            tid        <= 8'd0;
            timer      <= 16'd0;
            gap_cnt    <= 8'd0;
            retry_cnt  <= 4'd0;
            beat       <= 5'd0;
            size_q     <= 8'd0;
            req_valid  <= 1'b0;
            req_last   <= 1'b0;
            req_data   <= 64'd0;
            req_keep   <= 8'd0;
            req_user   <= 32'd0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            error_o    <= 1'b0;
            ed_ready_o <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_in) begin
                        size_q     <= nwr_size_in;
                        error_o    <= 1'b0;
                        ed_ready_o <= 1'b0;
                        retry_cnt  <= 4'd0;
                        busy_o     <= 1'b1;
                        req_valid  <= 1'b1;
                        req_data   <= db_beat(tid, DB_SELF);
                        req_keep   <= 8'hFF;
                        req_last   <= 1'b1;
                        req_user   <= {src_id, des_id};
                        state      <= SELF_DB;
                    end
                end

                SELF_DB: begin
                    if (tx_fire) begin
                        req_valid <= 1'b0;
                        tid       <= tid + 8'd1;
                        timer     <= 16'd0;
                        state     <= WAIT_RDY;
                    end
                end

                WAIT_RDY: begin
                    if (rsp_db && rsp_info == DB_READY) begin
                        ed_ready_o <= 1'b1;
                        req_valid  <= 1'b1;
                        req_data   <= nwr_hdr(tid, size_q);
                        req_keep   <= 8'hFF;
                        req_last   <= 1'b0;
                        req_user   <= {src_id, des_id};
                        state      <= NWR_HDR;
                    end else if (rsp_db && rsp_info == DB_NREADY) begin
                        retry_cnt <= retry_cnt + 4'd1;
                        gap_cnt   <= 8'd0;
                        if (retry_cnt + 4'd1 == 4'(MAX_RETRY)) begin
                            error_o <= 1'b1;
                            state   <= ERR;
                        end else begin
                            state   <= RETRY;
                        end
                    end else if (timer == 16'(RSP_TIMEOUT - 1)) begin
                        error_o <= 1'b1;
                        state   <= ERR;
                    end else begin
                        timer <= timer + 16'd1;
                    end
                end

                RETRY: begin
                    if (gap_cnt == 8'(RETRY_GAP - 1)) begin
                        req_valid <= 1'b1;
                        req_data  <= db_beat(tid, DB_SELF);
                        req_keep  <= 8'hFF;
                        req_last  <= 1'b1;
                        req_user  <= {src_id, des_id};
                        state     <= SELF_DB;
                    end else begin
                        gap_cnt <= gap_cnt + 8'd1;
                    end
                end

                NWR_HDR: begin
                    if (tx_fire) begin
                        beat     <= 5'd0;
                        req_data <= 64'd0;
                        req_last <= (last_idx == 5'd0);
                        req_keep <= (last_idx == 5'd0) ? last_keep : 8'hFF;
                        state    <= NWR_DATA;
                    end
                end

                NWR_DATA: begin
                    if (tx_fire) begin
                        if (req_last) begin
                            tid      <= tid + 8'd1;
                            req_data <= db_beat(tid + 8'd1, DB_DATA);
                            req_keep <= 8'hFF;
                            req_last <= 1'b1;
                            state    <= DATA_DB;
                        end else begin
                            beat     <= next_beat;
                            req_data <= {59'd0, next_beat};
                            req_last <= (next_beat == last_idx);
                            req_keep <= (next_beat == last_idx) ? last_keep : 8'hFF;
                        end
                    end
                end

                DATA_DB: begin
                    if (tx_fire) begin
                        req_valid <= 1'b0;
                        tid       <= tid + 8'd1;
                        timer     <= 16'd0;
                        state     <= WAIT_ACK;
                    end
                end

                WAIT_ACK: begin
                    if (rsp_db && rsp_info == DB_DATA) begin
                        done_o <= 1'b1;
                        busy_o <= 1'b0;
                        state  <= IDLE;
                    end else if (timer == 16'(RSP_TIMEOUT - 1)) begin
                        error_o <= 1'b1;
                        state   <= ERR;
                    end else begin
                        timer <= timer + 16'd1;
                    end
                end

                ERR: begin
                    busy_o <= 1'b0;
                    state  <= IDLE;
                end

                default: begin
                    req_valid <= 1'b0;
                    busy_o    <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_db_req.sv
// Self-checking bench for db_req: scripted doorbell responder plus a scoreboard of expected ireq beats.
module tb_db_req;

    localparam logic [33:0] NWR_ADDR    = 34'h2_1234_5678;
    localparam int          MAX_RETRY   = 3;
    localparam int          RETRY_GAP   = 8;
    localparam int          RSP_TIMEOUT = 64;
    localparam logic [15:0] SRC_ID      = 16'h00A5;
    localparam logic [15:0] DES_ID      = 16'h005A;

    typedef struct {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
    } beat_t;

    logic       log_clk = 1'b0;
    logic       log_rst_n = 1'b0;
    logic       start_in = 1'b0;
    logic [7:0] nwr_size_in = 8'd0;
    logic       busy_o, done_o, error_o, ed_ready_o;

    db_req_if srio();

    db_req #(
        .NWR_ADDR(NWR_ADDR),
        .MAX_RETRY(MAX_RETRY),
        .RETRY_GAP(RETRY_GAP),
        .RSP_TIMEOUT(RSP_TIMEOUT)
    ) dut (
        .log_clk(log_clk),
        .log_rst_n(log_rst_n),
        .src_id(SRC_ID),
        .des_id(DES_ID),
        .start_in(start_in),
        .nwr_size_in(nwr_size_in),
        .srio(srio),
        .busy_o(busy_o),
        .done_o(done_o),
        .error_o(error_o),
        .ed_ready_o(ed_ready_o)
    );

    always #5 log_clk = ~log_clk;

    beat_t       expQ[$];
    logic [19:0] planQ[$];
    logic [19:0] pendQ[$];
    logic [7:0]  tbTid = 8'd0;
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          doneCnt = 0;
    int          beatCnt = 0;
    int          selfDbCnt = 0;
    int          lastSelfCyc = 0;
    int          minSelfGap = 0;
    int          endCyc = 0;
    bit          randReady = 0;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic pushDb(input logic [15:0] info);
        beat_t b;
        b.data = {tbTid, 4'hA, 4'h0, 1'b0, 2'h1, 1'b0, 12'h0, info, 16'h0};
        b.keep = 8'hFF;
        b.last = 1'b1;
        expQ.push_back(b);
        tbTid++;
    endtask

    task automatic pushNwr(input logic [7:0] size);
        beat_t b;
        int bytes = int'(size) + 1;
        int nb    = (bytes + 7) / 8;
        int rem   = bytes % 8;
        b.data = {tbTid, 4'h5, 4'h4, 1'b0, 2'h1, 1'b0, size, 2'b00, NWR_ADDR};
        b.keep = 8'hFF;
        b.last = 1'b0;
        expQ.push_back(b);
        for (int k = 0; k < nb; k++) begin
            b.data = 64'(k);
            b.last = (k == nb - 1);
            b.keep = (k == nb - 1 && rem != 0) ? ~(8'hFF >> rem) : 8'hFF;
            expQ.push_back(b);
        end
        tbTid++;
    endtask

    initial forever begin
        @(posedge log_clk);
        cyc++;
    end

    initial begin
        srio.ireq_tready_in = 1'b1;
        forever begin
            @(posedge log_clk);
            #1;
            srio.ireq_tready_in = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Responder: plays queued doorbell responses, one every few cycles, each valid for one cycle.
    initial begin
        int rspWait = 0;
        logic [19:0] r;
        srio.iresp_tvalid_in = 1'b0;
        srio.iresp_tlast_in  = 1'b0;
        srio.iresp_tdata_in  = 64'd0;
        srio.iresp_tkeep_in  = 8'd0;
        srio.iresp_tuser_in  = 32'd0;
        forever begin
            @(posedge log_clk);
            #1;
            srio.iresp_tvalid_in = 1'b0;
            srio.iresp_tlast_in  = 1'b0;
            if (pendQ.size() != 0) begin
                rspWait++;
                if (rspWait >= 3) begin
                    r = pendQ.pop_front();
                    srio.iresp_tvalid_in = 1'b1;
                    srio.iresp_tlast_in  = 1'b1;
                    srio.iresp_tkeep_in  = 8'hFF;
                    srio.iresp_tuser_in  = {DES_ID, SRC_ID};
                    srio.iresp_tdata_in  = {8'h00, r[19:16], 4'h0, 1'b0, 2'h1, 1'b0, 12'h0, r[15:0], 16'h0};
                    rspWait = 0;
                end
            end else begin
                rspWait = 0;
            end
        end
    end

    // Monitor: scores each accepted ireq beat, checks hold under stall, triggers scripted responses.
    initial begin
        bit stalled = 0;
        logic [63:0] heldData = 64'd0;
        beat_t e;
        forever begin
            @(negedge log_clk);
            if (!log_rst_n) begin
                stalled = 0;
            end else begin
                if (done_o) doneCnt++;
                if (stalled) begin
                    checkOutput("hold_valid", 64'(srio.ireq_tvalid_o), 64'd1);
                    if (srio.ireq_tvalid_o) checkOutput("hold_data", srio.ireq_tdata_o, heldData);
                end
                if (srio.ireq_tvalid_o && srio.ireq_tready_in) begin
                    stalled = 0;
                    beatCnt++;
                    checkOutput("beat_expected", 64'(expQ.size() != 0), 64'd1);
                    if (expQ.size() != 0) begin
                        e = expQ.pop_front();
                        checkOutput("beat_data", srio.ireq_tdata_o, e.data);
                        checkOutput("beat_keep", 64'(srio.ireq_tkeep_o), 64'(e.keep));
                        checkOutput("beat_last", 64'(srio.ireq_tlast_o), 64'(e.last));
                        checkOutput("beat_user", 64'(srio.ireq_tuser_o), 64'({SRC_ID, DES_ID}));
                    end
                    if (srio.ireq_tdata_o[55:52] == 4'hA) begin
                        if (srio.ireq_tdata_o[31:16] == 16'h0101) begin
                            if (selfDbCnt > 0 && (minSelfGap == 0 || cyc + 1 - lastSelfCyc < minSelfGap))
                                minSelfGap = cyc + 1 - lastSelfCyc;
                            selfDbCnt++;
                            lastSelfCyc = cyc + 1;
                        end
                        while (planQ.size() != 0 && planQ[0][19:16] != 4'hA) pendQ.push_back(planQ.pop_front());
                        if (planQ.size() != 0) pendQ.push_back(planQ.pop_front());
                    end
                end else if (srio.ireq_tvalid_o) begin
                    stalled  = 1;
                    heldData = srio.ireq_tdata_o;
                end else begin
                    stalled = 0;
                end
            end
        end
    end

    task automatic applyStimulus(input logic [7:0] size, input int notReady, input bit expectReady,
                                 input bit withJunk);
        int nSelf = expectReady ? notReady + 1 : (notReady == 0 ? 1 : notReady);
        if (withJunk) planQ.push_back({4'h5, 16'h0100});
        for (int i = 0; i < notReady; i++) planQ.push_back({4'hA, 16'h01FF});
        if (expectReady) begin
            planQ.push_back({4'hA, 16'h0100});
            planQ.push_back({4'hA, 16'h0200});
        end
        for (int i = 0; i < nSelf; i++) pushDb(16'h0101);
        if (expectReady) begin
            pushNwr(size);
            pushDb(16'h0200);
        end
        doneCnt    = 0;
        selfDbCnt  = 0;
        minSelfGap = 0;
        @(posedge log_clk);
        #1;
        nwr_size_in = size;
        start_in    = 1'b1;
        @(posedge log_clk);
        #1;
        start_in = 1'b0;
        @(negedge log_clk);
        checkOutput("busy_after_start", 64'(busy_o), 64'd1);
        checkOutput("error_cleared", 64'(error_o), 64'd0);
        checkOutput("ready_cleared", 64'(ed_ready_o), 64'd0);
    endtask

    task automatic waitEnd(input int budget);
        bit seen = 0;
        for (int n = 0; n < budget && !seen; n++) begin
            @(negedge log_clk);
            if (done_o || error_o) begin
                seen   = 1;
                endCyc = cyc;
            end
        end
        checkOutput("seq_finished", 64'(seen), 64'd1);
        repeat (10) @(negedge log_clk);
    endtask

    task automatic checkEnd(input string tag, input bit expectReady, input int nSelf);
        checkOutput({tag, "_done_pulses"}, 64'(doneCnt), expectReady ? 64'd1 : 64'd0);
        checkOutput({tag, "_error"}, 64'(error_o), expectReady ? 64'd0 : 64'd1);
        checkOutput({tag, "_ed_ready"}, 64'(ed_ready_o), 64'(expectReady));
        checkOutput({tag, "_busy"}, 64'(busy_o), 64'd0);
        checkOutput({tag, "_beats_left"}, 64'(expQ.size()), 64'd0);
        checkOutput({tag, "_self_db"}, 64'(selfDbCnt), 64'(nSelf));
    endtask

    initial begin
        int startBeats;
        bit reached;
        $display("[TB] start");
        repeat (3) @(posedge log_clk);
        #1;
        checkOutput("rst_tvalid", 64'(srio.ireq_tvalid_o), 64'd0);
        checkOutput("rst_tlast", 64'(srio.ireq_tlast_o), 64'd0);
        checkOutput("rst_tkeep", 64'(srio.ireq_tkeep_o), 64'd0);
        checkOutput("rst_tready", 64'(srio.iresp_tready_o), 64'd1);
        checkOutput("rst_flags", 64'({busy_o, done_o, error_o, ed_ready_o}), 64'd0);
        log_rst_n = 1'b1;

        $display("[TB] basic size 0x0F with start while busy");
        applyStimulus(8'h0F, 0, 1, 0);
        repeat (2) @(posedge log_clk);
        #1;
        nwr_size_in = 8'hFF;
        start_in    = 1'b1;
        @(posedge log_clk);
        #1;
        start_in = 1'b0;
        waitEnd(500);
        checkEnd("basic", 1, 1);

        $display("[TB] size 0x02 with dropped non-doorbell response");
        applyStimulus(8'h02, 0, 1, 1);
        waitEnd(500);
        checkEnd("small", 1, 1);

        $display("[TB] size 0xFF with random back-pressure");
        randReady = 1;
        applyStimulus(8'hFF, 0, 1, 0);
        waitEnd(2000);
        checkEnd("full", 1, 1);
        randReady = 0;

        $display("[TB] two not-ready responses then ready, size 0x08");
        applyStimulus(8'h08, 2, 1, 0);
        waitEnd(1000);
        checkEnd("retry", 1, 3);
        checkOutput("retry_gap", 64'(minSelfGap >= RETRY_GAP), 64'd1);

        $display("[TB] retries exhausted");
        applyStimulus(8'h0F, MAX_RETRY, 0, 0);
        waitEnd(1000);
        checkEnd("exhaust", 0, MAX_RETRY);

        $display("[TB] response timeout");
        applyStimulus(8'h0F, 0, 0, 0);
        waitEnd(RSP_TIMEOUT + 200);
        checkEnd("timeout", 0, 1);
        checkOutput("timeout_cycles", 64'(endCyc - lastSelfCyc), 64'(RSP_TIMEOUT));

        $display("[TB] reset during NWRITE payload");
        startBeats = beatCnt;
        applyStimulus(8'hFF, 0, 1, 0);
        reached = 0;
        for (int n = 0; n < 500 && !reached; n++) begin
            @(negedge log_clk);
            if (beatCnt - startBeats >= 6) reached = 1;
        end
        checkOutput("reached_payload", 64'(reached), 64'd1);
        #2;
        log_rst_n = 1'b0;
        #1;
        checkOutput("async_rst_tvalid", 64'(srio.ireq_tvalid_o), 64'd0);
        checkOutput("async_rst_busy", 64'(busy_o), 64'd0);
        expQ.delete();
        planQ.delete();
        pendQ.delete();
        tbTid = 8'd0;
        repeat (2) @(negedge log_clk);
        #2;
        log_rst_n = 1'b1;
        applyStimulus(8'h0F, 0, 1, 0);
        waitEnd(500);
        checkEnd("post_reset", 1, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
